// File: rtl/sad_pkg.sv
// -----------------------------------------------------------------------------
// sad_pkg
//   Shared constants for the SAD datapath line/frame stores, plus a constant
//   ceil(log2) helper used to size RAM address ports from a line count.
//   No ports (package).
// -----------------------------------------------------------------------------
package sad_pkg;

    localparam int LINE_W_DEF = 640;
    localparam int DEPTH_DEF  = 480;
    localparam int ADDR_W_DEF = 9;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bank_ram.sv
// -----------------------------------------------------------------------------
// bank_ram
//   Simple dual-port synchronous RAM holding one frame: one write port and one
//   registered read port. Contents are never reset. The read register only
//   loads when re_i is high, so it holds its last value between reads.
//
// Ports
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write line address
//   wdata_i  in   write line data
//   re_i     in   read enable (loads the read register)
//   raddr_i  in   read line address
//   rdata_o  out  registered read data
// -----------------------------------------------------------------------------
module bank_ram
    import sad_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_pingpong_ram.sv
// -----------------------------------------------------------------------------
// frame_pingpong_ram
//   Double-buffered frame store. The writer fills one bank a line at a time
//   while the reader randomly accesses the other, fully written bank. Banks
//   swap on the writer's last line and on the reader's release. Refused writes
//   are counted (saturating) and out-of-range reads are flagged.
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   rst_n       in   synchronous active-low reset
//   wr_en       in   write request for one line
//   wr_data     in   line to store
//   wr_ready    out  current write bank can accept a line
//   wr_line     out  line index the next accepted write will occupy
//   frame_done  out  one-cycle pulse after a bank received its last line
//   rd_en       in   read request
//   rd_addr     in   line index to read
//   rd_release  in   reader is finished with the current read bank
//   rd_avail    out  read bank holds a complete frame
//   rd_data     out  registered read data
//   rd_valid    out  rd_data was loaded by the previous cycle's read
//   rd_err      out  one-cycle pulse for an out-of-range read
//   drop_cnt    out  saturating count of refused writes
// -----------------------------------------------------------------------------
module frame_pingpong_ram
    import sad_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [LINE_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] wr_line,
    output logic              frame_done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_release,
    output logic              rd_avail,
    output logic [LINE_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int BANK_AW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(DEPTH - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        full_q, full_d;
    logic [ADDR_W-1:0] wr_line_q, wr_line_d;
    logic              frame_done_q, frame_done_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_err_q, rd_err_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    // Which bank's read register currently drives rd_data.
    logic              rd_sel_q, rd_sel_d;
    // Forces rd_data to zero from reset until the first successful read,
    // since the RAM read registers themselves are not reset.
    logic              rd_zero_q, rd_zero_d;

    logic              wr_acc, wr_last, rel_acc, rd_in_range, rd_go;
    logic [LINE_W-1:0] rdata0, rdata1;

    assign wr_ready    = !full_q[wr_bank_q];
    assign rd_avail    = full_q[rd_bank_q];
    assign wr_acc      = wr_en && wr_ready;
    assign wr_last     = wr_acc && (wr_line_q == LAST_LINE);
    assign rel_acc     = rd_release && rd_avail;
    assign rd_in_range = (32'(rd_addr) < DEPTH);
    assign rd_go       = rd_en && rd_avail && rd_in_range;

    always_comb begin
        full_d       = full_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        wr_line_d    = wr_line_q;
        drop_cnt_d   = drop_cnt_q;
        rd_sel_d     = rd_sel_q;
        rd_zero_d    = rd_zero_q;
        frame_done_d = wr_last;
        rd_valid_d   = rd_go;
        rd_err_d     = rd_en && rd_avail && !rd_in_range;

        // Release clears first so a same-index set from a last-line write wins.
        if (rel_acc) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
        if (wr_acc) begin
            if (wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_line_d         = '0;
            end else begin
                wr_line_d = wr_line_q + ADDR_W'(1);
            end
        end
        if (wr_en && !wr_ready) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
        if (rd_go) begin
            rd_sel_d  = rd_bank_q;
            rd_zero_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            full_q       <= 2'b00;
            wr_line_q    <= '0;
            frame_done_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            drop_cnt_q   <= '0;
            rd_sel_q     <= 1'b0;
            rd_zero_q    <= 1'b1;
        end else begin
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            full_q       <= full_d;
            wr_line_q    <= wr_line_d;
            frame_done_q <= frame_done_d;
            rd_valid_q   <= rd_valid_d;
            rd_err_q     <= rd_err_d;
            drop_cnt_q   <= drop_cnt_d;
            rd_sel_q     <= rd_sel_d;
            rd_zero_q    <= rd_zero_d;
        end
    end

    // Only the bank selected for the access sees the enable; the other
    // bank's read register keeps its contents.
    bank_ram #(.LINE_W(LINE_W), .DEPTH(DEPTH), .AW(BANK_AW)) u_bank0 (
        .clk     (clk),
        .we_i    (wr_acc && !wr_bank_q),
        .waddr_i (wr_line_q[BANK_AW-1:0]),
        .wdata_i (wr_data),
        .re_i    (rd_go && !rd_bank_q),
        .raddr_i (rd_addr[BANK_AW-1:0]),
        .rdata_o (rdata0)
    );

    bank_ram #(.LINE_W(LINE_W), .DEPTH(DEPTH), .AW(BANK_AW)) u_bank1 (
        .clk     (clk),
        .we_i    (wr_acc && wr_bank_q),
        .waddr_i (wr_line_q[BANK_AW-1:0]),
        .wdata_i (wr_data),
        .re_i    (rd_go && rd_bank_q),
        .raddr_i (rd_addr[BANK_AW-1:0]),
        .rdata_o (rdata1)
    );

    assign rd_data    = rd_zero_q ? '0 : (rd_sel_q ? rdata1 : rdata0);
    assign rd_valid   = rd_valid_q;
    assign rd_err     = rd_err_q;
    assign frame_done = frame_done_q;
    assign wr_line    = wr_line_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_frame_pingpong_ram.sv
module tb_frame_pingpong_ram;

    localparam int LINE_W = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 16;
    localparam int CNT_W2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, wr_en, rd_en, rd_release;
    logic [LINE_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;

    logic              wr_ready_a, frame_done_a, rd_avail_a, rd_valid_a, rd_err_a;
    logic [ADDR_W-1:0] wr_line_a;
    logic [LINE_W-1:0] rd_data_a;
    logic [CNT_W-1:0]  drop_cnt_a;

    logic              wr_ready_b, frame_done_b, rd_avail_b, rd_valid_b, rd_err_b;
    logic [ADDR_W-1:0] wr_line_b;
    logic [LINE_W-1:0] rd_data_b;
    logic [CNT_W2-1:0] drop_cnt_b;

    frame_pingpong_ram #(.LINE_W(LINE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready_a), .wr_line(wr_line_a), .frame_done(frame_done_a),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
        .rd_avail(rd_avail_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .rd_err(rd_err_a), .drop_cnt(drop_cnt_a)
    );

    // Same stimulus, narrow drop counter to observe saturation.
    frame_pingpong_ram #(.LINE_W(LINE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready_b), .wr_line(wr_line_b), .frame_done(frame_done_b),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release),
        .rd_avail(rd_avail_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .rd_err(rd_err_b), .drop_cnt(drop_cnt_b)
    );

    // Reference model: a FIFO of complete frames (at most two can be held),
    // plus the partially written frame.
    typedef logic [LINE_W*DEPTH-1:0] frame_t;
    frame_t      fq[$];
    frame_t      cur;
    int          cur_n;
    int          drops;
    logic [LINE_W-1:0] e_rd_data;
    logic        e_rd_valid, e_rd_err, e_fd;

    int nchecks = 0;
    int nerr    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit     avail, ready;
        frame_t h;
        if (!rst_n) begin
            fq.delete();
            cur_n      = 0;
            drops      = 0;
            e_rd_data  = '0;
            e_rd_valid = 1'b0;
            e_rd_err   = 1'b0;
            e_fd       = 1'b0;
            return;
        end
        avail      = (fq.size() > 0);
        ready      = (fq.size() < 2);
        e_rd_valid = 1'b0;
        e_rd_err   = 1'b0;
        e_fd       = 1'b0;
        if (rd_en && avail) begin
            if (int'(rd_addr) < DEPTH) begin
                h          = fq[0];
                e_rd_data  = h[int'(rd_addr)*LINE_W +: LINE_W];
                e_rd_valid = 1'b1;
            end else begin
                e_rd_err = 1'b1;
            end
        end
        if (wr_en) begin
            if (ready) begin
                cur[cur_n*LINE_W +: LINE_W] = wr_data;
                cur_n++;
                if (cur_n == DEPTH) begin
                    fq.push_back(cur);
                    cur_n = 0;
                    e_fd  = 1'b1;
                end
            end else begin
                drops++;
            end
        end
        if (rd_release && avail) void'(fq.pop_front());
    endtask

    task automatic check_all();
        int dmax_a, dmax_b;
        dmax_a = (1 << CNT_W) - 1;
        dmax_b = (1 << CNT_W2) - 1;
        check("wr_ready",     32'(wr_ready_a),   32'(fq.size() < 2));
        check("rd_avail",     32'(rd_avail_a),   32'(fq.size() > 0));
        check("wr_line",      32'(wr_line_a),    32'(cur_n));
        check("frame_done",   32'(frame_done_a), 32'(e_fd));
        check("rd_valid",     32'(rd_valid_a),   32'(e_rd_valid));
        check("rd_err",       32'(rd_err_a),     32'(e_rd_err));
        check("rd_data",      32'(rd_data_a),    32'(e_rd_data));
        check("drop_cnt",     32'(drop_cnt_a),   32'((drops > dmax_a) ? dmax_a : drops));
        check("sat_drop_cnt", 32'(drop_cnt_b),   32'((drops > dmax_b) ? dmax_b : drops));
        check("sat_wr_ready", 32'(wr_ready_b),   32'(fq.size() < 2));
        check("sat_rd_avail", 32'(rd_avail_b),   32'(fq.size() > 0));
        check("sat_wr_line",  32'(wr_line_b),    32'(cur_n));
        check("sat_fdone",    32'(frame_done_b), 32'(e_fd));
        check("sat_rd_valid", 32'(rd_valid_b),   32'(e_rd_valid));
        check("sat_rd_err",   32'(rd_err_b),     32'(e_rd_err));
        check("sat_rd_data",  32'(rd_data_b),    32'(e_rd_data));
    endtask

    task automatic step(input logic we, input logic [LINE_W-1:0] wd,
                        input logic re, input logic [ADDR_W-1:0] ra, input logic rel);
        wr_en      = we;
        wr_data    = wd;
        rd_en      = re;
        rd_addr    = ra;
        rd_release = rel;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic write_frame(input logic [LINE_W-1:0] base);
        for (int i = 0; i < DEPTH; i++) step(1'b1, base + LINE_W'(i), 1'b0, '0, 1'b0);
    endtask

    initial begin
        cur   = '0;
        cur_n = 0;
        drops = 0;
        rst_n = 1'b0;
        wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;

        // Reset
        idle();
        idle();
        rst_n = 1'b1;

        // Simple frame, reads at 3 then 0
        step(1'b1, 8'h11, 1'b0, '0, 1'b0);
        step(1'b1, 8'h22, 1'b0, '0, 1'b0);
        step(1'b1, 8'h33, 1'b0, '0, 1'b0);
        step(1'b1, 8'h44, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, 3'd3, 1'b0);
        check("read3_literal", 32'(rd_data_a), 32'h44);
        step(1'b0, '0, 1'b1, 3'd0, 1'b0);
        check("read0_literal", 32'(rd_data_a), 32'h11);
        idle();

        // Overlap: write bank 1 while reading bank 0 every cycle
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 8'hA0 + LINE_W'(i), 1'b1, ADDR_W'(3 - i), 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1, 3'd2, 1'b0);
        check("overlap_a2", 32'(rd_data_a), 32'hA2);

        // Overflow: fill the free bank, then five refused writes
        write_frame(8'hB0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'hEE, 1'b0, '0, 1'b0);
        check("drop5", 32'(drop_cnt_a), 32'd5);
        check("drop_sat", 32'(drop_cnt_b), 32'd3);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, ADDR_W'(i), 1'b0);

        // Out-of-range reads, then drain both banks
        step(1'b0, '0, 1'b1, 3'd4, 1'b0);
        step(1'b0, '0, 1'b1, 3'd7, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, ADDR_W'(i), 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1);
        // Ignored read / release / bad address with nothing available
        step(1'b0, '0, 1'b1, 3'd1, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1, 3'd5, 1'b1);

        // Last-line write + read + release in the same cycle
        write_frame(8'hC0);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 8'hD0 + LINE_W'(i), 1'b0, '0, 1'b0);
        step(1'b1, 8'hD3, 1'b1, 3'd1, 1'b1);
        check("simul_old_bank", 32'(rd_data_a), 32'hC1);
        step(1'b0, '0, 1'b1, 3'd1, 1'b0);
        check("simul_new_bank", 32'(rd_data_a), 32'hD1);
        // Read + release with both banks full
        write_frame(8'hE0);
        step(1'b0, '0, 1'b1, 3'd0, 1'b1);
        step(1'b0, '0, 1'b1, 3'd0, 1'b0);
        check("after_release", 32'(rd_data_a), 32'hE0);

        // Reset mid-frame
        step(1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b1, 8'h51, 1'b0, '0, 1'b0);
        step(1'b1, 8'h52, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        write_frame(8'h60);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, ADDR_W'(DEPTH - 1 - i), 1'b0);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            step(1'($urandom_range(0, 1)), LINE_W'($urandom),
                 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 5)),
                 ($urandom_range(0, 99) < 15));
        end
        rst_n = 1'b1;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/frame_pingpong_ram.md
# frame_pingpong_ram

Parametrised double-buffered (ping-pong) frame store that replaces the single-bank line RAM in the SAD datapath. The pixel writer fills one bank sequentially, one line per write, while the SAD engine reads the other bank with random line addresses. Banks swap on explicit handshakes, so capture of frame N+1 overlaps processing of frame N. Dropped writes are counted, and out-of-range reads are flagged.

## Interface
- `LINE_W`, default 640: bits per stored line.
- `DEPTH`, default 480: lines per frame (per bank).
- `ADDR_W`, default 9: line-address width. Must satisfy 2^ADDR_W ≥ DEPTH.
- `CNT_W`, default 16: width of the drop counter.

- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: synchronous reset, active low, sampled on the rising edge of `clk`.
- `wr_en` input 1: write request for one line.
- `wr_data` input LINE_W: line to store.
- `wr_ready` output 1: the current write bank can accept a line.
- `wr_line` output ADDR_W: index the next accepted line will occupy.
- `frame_done` output 1: one-cycle pulse when a bank receives its last line.
- `rd_en` input 1: read request.
- `rd_addr` input ADDR_W: line index to read.
- `rd_release` input 1: reader has finished with the current read bank.
- `rd_avail` output 1: the read bank holds a complete frame.
- `rd_data` output LINE_W: registered read data.
- `rd_valid` output 1: `rd_data` is valid this cycle.
- `rd_err` output 1: one-cycle pulse for an out-of-range read.
- `drop_cnt` output CNT_W: saturating count of refused writes.

## Operation
- **State.** `wr_bank`, `rd_bank` (1 bit each); `full[1:0]`; write pointer `wr_line`.
- **Reset** (`rst_n`=0 at an edge): `wr_bank`=0, `rd_bank`=0, `full`=00, `wr_line`=0, `rd_data`=0, `rd_valid`=0, `rd_err`=0, `frame_done`=0, `drop_cnt`=0.
  - Resulting outputs: `wr_ready`=1, `rd_avail`=0.
  - Memory contents are not cleared.
  - Reset mid-frame discards the partial frame and any full banks.
- **Write acceptance.**
  - `wr_ready` = !`full[wr_bank]` (combinational).
  - An accepted write is `wr_en`·`wr_ready`. It stores `wr_data` at bank `wr_bank`, line `wr_line`, then increments `wr_line`.
- **Last line.** An accepted write with `wr_line`=DEPTH-1 additionally:
  - sets `full[wr_bank]`,
  - sets `wr_line` to 0,
  - toggles `wr_bank`,
  - pulses `frame_done` on the next cycle.
- **Refused write.** `wr_en` while `wr_ready`=0 stores nothing. `drop_cnt` increments and saturates at 2^CNT_W-1.
- **Read availability.** `rd_avail` = `full[rd_bank]` (combinational).
- **Read request.** `rd_en`·`rd_avail` with `rd_addr` < DEPTH loads `rd_data` from bank `rd_bank`, line `rd_addr`, and sets `rd_valid`=1 the next cycle.
  - With `rd_addr` ≥ DEPTH: `rd_err` pulses, `rd_valid`=0, `rd_data` holds.
  - `rd_en` while `rd_avail`=0 is ignored: `rd_valid`=0, no error.
- **Read hold.** Otherwise `rd_valid`=0 and `rd_data` holds its last value.
- **Release.** `rd_release`·`rd_avail` clears `full[rd_bank]` and toggles `rd_bank`. `rd_release` while `rd_avail`=0 is ignored.
- **Simultaneous events.**
  - `rd_en` with `rd_release` in the same cycle: the read uses the pre-release bank, then the release takes effect.
  - A last-line write and a release in the same cycle both take effect. If they target the same bank index, the set from the write wins.
    - This is unreachable in normal use, because a full bank never accepts writes.
- **Ordering.** Banks fill and drain strictly alternately; `rd_bank` always trails `wr_bank`.

## Timing
- Write-to-memory: the line is committed at the accepting edge.
- The earliest read of a line is the cycle after `frame_done` asserts.
- Read latency is 1 cycle: request at edge k, `rd_data`/`rd_valid` valid after edge k.
- Back-to-back reads run at one per cycle, with no bubbles.
- `wr_ready`, `rd_avail`, and `wr_line` update at the edge after the causing event.
- A released bank is writable in the next cycle.
- Throughput: one line written and one line read per cycle, concurrently.

## Structure
- **Shared package `sad_pkg`:** constants `LINE_W_DEF`=640, `DEPTH_DEF`=480, and `ADDR_W_DEF`=9, plus function `clog2` for deriving `ADDR_W`.
- **Sub-module `bank_ram`:** simple dual-port synchronous RAM with 1 write port and 1 registered read port, parameters `LINE_W` and `DEPTH`. Instantiated twice.
- **Top level** holds the pointers, the full flags, the read-side mux and register, the drop counter, and the pulse logic.

## Test plan
- **Reset and simple frame** (LINE_W=8, DEPTH=4): write 0x11, 0x22, 0x33, 0x44.
  - `frame_done` pulses once.
  - `rd_avail`=1 and `wr_line`=0.
  - Reads at addresses 3, 0 return 0x44 then 0x11, each 1 cycle after the request.
- **Overlap:** during reads of bank 0, write frame 0xA0–0xA3 into bank 1.
  - `rd_release` makes bank 1 readable the next cycle, and address 2 returns 0xA2.
- **Overflow:** fill both banks without release, then issue 5 more `wr_en`.
  - `wr_ready`=0 and `drop_cnt`=5.
  - The stored data is unchanged.
  - With CNT_W=2, the count saturates at 3.
- **Errors/ignores:** `rd_addr`=4 with DEPTH=4 gives an `rd_err` pulse with `rd_valid`=0. `rd_en` or `rd_release` with `rd_avail`=0 changes nothing.
- **Simultaneous events:** `rd_en`+`rd_release` in the same cycle returns data from the old bank. A last-line write and a release in the same cycle leave `full`=10 or 01 as expected.
- **Reset mid-frame:** after 2 of 4 writes, drive `rst_n`=0 for 1 cycle.
  - `wr_line`=0, `rd_avail`=0, `drop_cnt`=0.
  - A new full frame then reads back correctly.
